// File: rtl/salamander_pkg.sv
// Shared types for the salamander core and its byte-stream program loader.
package salamander_pkg;

    typedef enum logic [3:0] {
        OP_INC = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_NOP = 4'd3,
        OP_ST  = 4'd4,
        OP_LD  = 4'd5,
        OP_JMP = 4'd6,
        OP_RTN = 4'd7
    } op_code_e;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        REG_TO_REG = 4'd1,
        MEM_TO_REG = 4'd2,
        OP_REG     = 4'd3
    } mem_op_e;

    typedef struct packed {
        op_code_e    op_code;
        mem_op_e     mem_op;
        logic [3:0]  left;
        logic [3:0]  right;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHECK = 3'd5
    } loader_state_e;

    function automatic logic [15:0] encode(op_code_e op, mem_op_e mo,
                                           logic [3:0] l, logic [3:0] r);
        instr_t i;
        i.op_code = op;
        i.mem_op  = mo;
        i.left    = l;
        i.right   = r;
        return i;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes 16-bit words into core memory and
// releases the core only after the frame XOR checksum matches.
module program_loader
    import salamander_pkg::*;
#(
    parameter int          DATA_SIZE = 16,
    parameter int          ADDR_SIZE = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 W,
    output logic                 OVERWRITE,
    output logic [ADDR_SIZE-1:0] ADDR,
    output logic [DATA_SIZE-1:0] DATA_WR,
    output logic                 core_run,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int         IW    = ADDR_SIZE + 1;
    localparam logic [8:0] MAX_N = 9'(1 << ADDR_SIZE);

    loader_state_e        state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, n_q, n_d, idx_inc;
    logic [7:0]           hi_q, hi_d, xor_q, xor_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 w_q, w_d, rdy_q, rdy_d;
    logic                 run_q, run_d, done_q, done_d, err_q, err_d;
    logic                 fire;

    assign fire    = in_valid && rdy_q;
    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        addr_d  = addr_q;
        data_d  = data_q;
        w_d     = 1'b0;
        run_d   = run_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire && in_data == SYNC_BYTE) begin
                    state_d = S_COUNT;
                    run_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_COUNT: begin
                if (fire) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        n_d     = in_data[IW-1:0];
                        idx_d   = '0;
                        xor_d   = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (fire) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (fire) begin
                    xor_d   = xor_q ^ in_data;
                    addr_d  = idx_q[ADDR_SIZE-1:0];
                    data_d  = DATA_SIZE'({hi_q, in_data});
                    w_d     = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (fire) begin
                    if (in_data == xor_q) begin
                        done_d = 1'b1;
                        run_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Ready is registered: decided from where the FSM is heading.
        rdy_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            hi_q    <= '0;
            xor_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            w_q     <= 1'b0;
            rdy_q   <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            w_q     <= w_d;
            rdy_q   <= rdy_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = rdy_q;
    assign W         = w_q;
    assign OVERWRITE = w_q;
    assign ADDR      = addr_q;
    assign DATA_WR   = data_q;
    assign core_run  = run_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule
